// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display datapath.
// Digit index 0 is centiseconds ones, index 5 is minutes tens.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'b100,
      RUNNING = 3'b001,
      CLEAR   = 3'b010
   } state_t;

   localparam int NUM_DIGITS = 6;

   localparam logic [7:0] SEG_DP = 8'h80;

   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
   };

   // Rollover value of each BCD digit: cs_o, cs_t, s_o, s_t, m_o, m_t
   localparam logic [3:0] DIGIT_MAX [0:NUM_DIGITS-1] = '{
      4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5
   };

   // Decimal point lit on minutes ones and seconds ones
   localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-high seven-segment pattern (bit0=a .. bit6=g).
// Non-decimal codes blank the digit.
module seg7_decode
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h00;
      if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i][6:0];
   end

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS.cc BCD stopwatch driven by the one-hot mode code, decoded onto ss5..ss0.
// Optional STOPWATCH_BLINK_EN flashes the paused, nonzero display at 1 Hz.
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_CS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] mode,
   output logic [7:0] ss5,
   output logic [7:0] ss4,
   output logic [7:0] ss3,
   output logic [7:0] ss2,
   output logic [7:0] ss1,
   output logic [7:0] ss0,
   output logic       running,
   output logic       wrap
);

   localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_CS - 1);

   logic [PW-1:0]                  pre_q, pre_d;
   logic [NUM_DIGITS-1:0][3:0]     digit_q, digit_d;
   logic                           wrap_q, wrap_d;
   logic                           tick, carry, blank;
   logic [NUM_DIGITS-1:0][7:0]     seg;

   assign running = (mode == RUNNING);
   assign tick    = running && (pre_q == PRE_LAST);

   // Ripple carry across digits; a carry out of the top digit is the rollover
   always_comb begin
      digit_d = digit_q;
      pre_d   = pre_q;
      wrap_d  = 1'b0;
      carry   = tick;
      case (mode)
         RUNNING: begin
            pre_d = tick ? '0 : pre_q + 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (carry) begin
                  if (digit_q[i] == DIGIT_MAX[i]) begin
                     digit_d[i] = '0;
                  end else begin
                     digit_d[i] = digit_q[i] + 4'd1;
                     carry      = 1'b0;
                  end
               end
            end
            wrap_d = carry;
         end
         CLEAR: begin
            digit_d = '0;
            pre_d   = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q   <= '0;
         digit_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         digit_q <= digit_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef STOPWATCH_BLINK_EN
   localparam int BLINK_PERIOD = 100 * TICKS_PER_CS;
   localparam int BW           = $clog2(BLINK_PERIOD + 1);

   logic [BW-1:0] blink_q, blink_d;
   logic          blink_act;

   assign blink_act = (mode == IDLE) && (digit_q != '0);

   always_comb begin
      blink_d = '0;
      if (blink_act && (blink_q != BW'(BLINK_PERIOD - 1))) blink_d = blink_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) blink_q <= '0;
      else     blink_q <= blink_d;
   end

   // Blank half of each period comes first
   assign blank = blink_act && (blink_q < BW'(50 * TICKS_PER_CS));
`else
   assign blank = 1'b0;
`endif

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      logic [6:0] seg7;
      seg7_decode u_dec (
         .bcd_i (digit_q[g]),
         .seg_o (seg7)
      );
      assign seg[g] = blank ? 8'h00 : ((DP_MASK[g] ? SEG_DP : 8'h00) | {1'b0, seg7});
   end

   assign ss0  = seg[0];
   assign ss1  = seg[1];
   assign ss2  = seg[2];
   assign ss3  = seg[3];
   assign ss4  = seg[4];
   assign ss5  = seg[5];
   assign wrap = wrap_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench: dut_a runs at 1 clock per centisecond, dut_b at 4.
module tb_stopwatch_display;

`ifdef STOPWATCH_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   localparam logic [2:0] M_IDLE = 3'b100;
   localparam logic [2:0] M_RUN  = 3'b001;
   localparam logic [2:0] M_CLR  = 3'b010;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] mode_a = M_IDLE, mode_b = M_IDLE;
   logic [7:0] a5, a4, a3, a2, a1, a0, b5, b4, b3, b2, b1, b0;
   logic run_a, run_b, wrap_a, wrap_b;

   int nvec = 0;
   int nmis = 0;

   logic [7:0] segt [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                             8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   always #5 clk = ~clk;

   stopwatch_display #(.TICKS_PER_CS(1)) dut_a (
      .clk(clk), .rst(rst), .mode(mode_a),
      .ss5(a5), .ss4(a4), .ss3(a3), .ss2(a2), .ss1(a1), .ss0(a0),
      .running(run_a), .wrap(wrap_a)
   );

   stopwatch_display #(.TICKS_PER_CS(4)) dut_b (
      .clk(clk), .rst(rst), .mode(mode_b),
      .ss5(b5), .ss4(b4), .ss3(b3), .ss2(b2), .ss1(b1), .ss0(b0),
      .running(run_b), .wrap(wrap_b)
   );

   typedef struct {
      bit          dut;
      logic [2:0]  mode;
      int          edges;
      logic [23:0] bcd;   // m_t m_o s_t s_o cs_t cs_o
      logic        w;
      logic        r;
      bit          bl;    // display blanked when blinking is built in
   } vec_t;

   vec_t v[$];

   function automatic logic [47:0] exp_segs(input logic [23:0] bcd, input bit blank);
      logic [47:0] e;
      logic [3:0]  d;
      e = '0;
      if (!blank) begin
         for (int i = 0; i < 6; i++) begin
            d = bcd[i*4 +: 4];
            e[i*8 +: 8] = segt[d] | ((i == 2 || i == 4) ? 8'h80 : 8'h00);
         end
      end
      return e;
   endfunction

   task automatic chk(input string nm, input bit d, input logic [23:0] bcd,
                      input logic w, input logic r, input bit bl);
      logic [47:0] e, a;
      logic aw, ar;
      e  = exp_segs(bcd, BLINK && bl);
      a  = d ? {b5, b4, b3, b2, b1, b0} : {a5, a4, a3, a2, a1, a0};
      aw = d ? wrap_b : wrap_a;
      ar = d ? run_b : run_a;
      nvec++;
      if (a !== e) begin
         nmis++;
         $display("FAIL %s segs got %h want %h", nm, a, e);
      end
      nvec++;
      if (aw !== w) begin
         nmis++;
         $display("FAIL %s wrap got %b want %b", nm, aw, w);
      end
      nvec++;
      if (ar !== r) begin
         nmis++;
         $display("FAIL %s running got %b want %b", nm, ar, r);
      end
   endtask

   task automatic apply(input int i);
      if (v[i].dut) mode_b = v[i].mode;
      else          mode_a = v[i].mode;
      repeat (v[i].edges) @(negedge clk);
      #1;
      chk($sformatf("vec%0d", i), v[i].dut, v[i].bcd, v[i].w, v[i].r, v[i].bl);
   endtask

   initial begin
      int na;
      // dut_a, one tick per clock
      v.push_back('{0, M_RUN,   100,  24'h000100, 0, 1, 0});
      v.push_back('{0, M_RUN,   427,  24'h000527, 0, 1, 0});
      v.push_back('{0, M_IDLE,  50,   24'h000527, 0, 0, 0});
      v.push_back('{0, 3'b000,  20,   24'h000527, 0, 0, 0});
      v.push_back('{0, M_CLR,   1,    24'h000000, 0, 0, 0});
      v.push_back('{0, M_RUN,   3,    24'h000003, 0, 1, 0});
      v.push_back('{0, M_RUN,   97,   24'h000100, 0, 1, 0});
      v.push_back('{0, M_RUN,   5900, 24'h010000, 0, 1, 0});
      v.push_back('{0, 3'b111,  5,    24'h010000, 0, 0, 0});
      v.push_back('{0, 3'b011,  5,    24'h010000, 0, 0, 0});
      v.push_back('{0, M_CLR,   2,    24'h000000, 0, 0, 0});
      na = v.size();
      // dut_b, four clocks per tick, plus blink phases
      v.push_back('{1, M_RUN,   3,    24'h000000, 0, 1, 0});
      v.push_back('{1, M_RUN,   1,    24'h000001, 0, 1, 0});
      v.push_back('{1, M_RUN,   4,    24'h000002, 0, 1, 0});
      v.push_back('{1, M_IDLE,  0,    24'h000002, 0, 0, 1});
      v.push_back('{1, M_IDLE,  199,  24'h000002, 0, 0, 1});
      v.push_back('{1, M_IDLE,  1,    24'h000002, 0, 0, 0});
      v.push_back('{1, M_IDLE,  199,  24'h000002, 0, 0, 0});
      v.push_back('{1, M_IDLE,  1,    24'h000002, 0, 0, 1});
      v.push_back('{1, M_RUN,   2,    24'h000002, 0, 1, 0});
      v.push_back('{1, M_CLR,   1,    24'h000000, 0, 0, 0});
      v.push_back('{1, M_IDLE,  10,   24'h000000, 0, 0, 0});
      v.push_back('{1, M_RUN,   3,    24'h000000, 0, 1, 0});
      v.push_back('{1, M_RUN,   1,    24'h000001, 0, 1, 0});

      #3;
      chk("reset_a", 0, 24'h000000, 0, 0, 0);
      chk("reset_b", 1, 24'h000000, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < na; i++) apply(i);

      // Rollover: preload 59:59.98 under a holding code, then run across the wrap
      mode_a = 3'b000;
      force dut_a.digit_q = 24'h595998;
      @(negedge clk);
      release dut_a.digit_q;
      @(negedge clk);
      #1 chk("preload", 0, 24'h595998, 0, 0, 0);
      mode_a = M_RUN;
      @(negedge clk);
      #1 chk("wrap_pre", 0, 24'h595999, 0, 1, 0);
      @(negedge clk);
      #1 chk("wrap_hit", 0, 24'h000000, 1, 1, 0);
      @(negedge clk);
      #1 chk("wrap_post", 0, 24'h000001, 0, 1, 0);

      // Async reset mid-count at 00:12.34
      mode_a = M_CLR;
      @(negedge clk);
      mode_a = M_RUN;
      repeat (1234) @(negedge clk);
      #1 chk("pre_rst", 0, 24'h001234, 0, 1, 0);
      #2 rst = 1'b1;
      #1 chk("mid_rst", 0, 24'h000000, 0, 1, 0);
      mode_a = M_IDLE;
      @(negedge clk);
      rst = 1'b0;

      for (int i = na; i < v.size(); i++) apply(i);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
